// File: rtl/button_pulser.sv
// ----------------------------------------------------------------------------
// button_pulser
//
// Turns a raw, bouncing push-button into a clean debounced level plus
// single-cycle press / release strobes. The raw input is brought into the
// clock domain by a 2-flop synchronizer, then a 4-state FSM with a debounce
// counter only accepts a change after DEBOUNCE_CYCLES consecutive stable
// synchronized samples following the first changed sample.
//
// Parameters:
//   DEBOUNCE_CYCLES - stable samples needed to accept a change (1 .. 2^CNT_W)
//   CNT_W           - width of the debounce counter
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   btn           in   raw asynchronous button, active-high
//   level         out  debounced button state (registered)
//   press         out  one-cycle pulse on accepted 0->1 (registered)
//   release_pulse out  one-cycle pulse on accepted 1->0 (registered)
//
// The falling-edge strobe is named release_pulse because "release" is a
// reserved word in SystemVerilog.
// ----------------------------------------------------------------------------
module button_pulser #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press,
    output logic release_pulse
);

    typedef enum logic [1:0] {
        IDLE         = 2'b00,
        PRESS_WAIT   = 2'b01,
        HELD         = 2'b10,
        RELEASE_WAIT = 2'b11
    } state_t;

    // The counter only ever reaches D-1, so even D = 2^CNT_W fits without wrap.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic           s1_r;
    logic           s2_r;
    state_t         state_r;
    state_t         state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic           level_r;
    logic           level_s;
    logic           press_r;
    logic           press_s;
    logic           release_r;
    logic           release_s;
    logic           sync_s;

    assign sync_s = s2_r;

    // Two-flop synchronizer for the asynchronous button input.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= btn;
            s2_r <= s1_r;
        end
    end

    // FSM state, debounce counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= CNT_ZERO;
            level_r   <= 1'b0;
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            level_r   <= level_s;
            press_r   <= press_s;
            release_r <= release_s;
        end
    end

    // Next-state, counter and output decode.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        press_s   = 1'b0;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync_s) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!sync_s) begin
                    // bounce: drop back without a pulse
                    state_s = IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_s = HELD;
                    press_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (!sync_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = HELD;
                end
            end
            RELEASE_WAIT: begin
                if (sync_s) begin
                    // bounce: return to held without a pulse
                    state_s = HELD;
                end else if (cnt_r == CNT_LAST) begin
                    state_s   = IDLE;
                    release_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
        // level follows the upper state bit of the next state
        if ((state_s == HELD) || (state_s == RELEASE_WAIT)) begin
            level_s = 1'b1;
        end else begin
            level_s = 1'b0;
        end
    end

    assign level         = level_r;
    assign press         = press_r;
    assign release_pulse = release_r;

endmodule

// File: tb/tb_button_pulser.sv
// ----------------------------------------------------------------------------
// tb_button_pulser
//
// Self-checking bench for button_pulser with D=4, CNT_W=3. A behavioural
// reference model tracks how many consecutive synchronized samples disagree
// with the debounced level; a change is accepted once that run reaches D+1.
// Directed table vectors and hand-written corner sequences are followed by
// randomized button activity, all compared cycle by cycle against the model.
// ----------------------------------------------------------------------------
module tb_button_pulser;

    localparam int D = 4;

    logic clk;
    logic rst;
    logic btn;
    logic level;
    logic press;
    logic release_pulse;

    int checks = 0;
    int errors = 0;
    int n_press = 0;
    int n_rel = 0;
    logic last_was_press = 1'b0;

    // reference model state
    logic m_s1, m_s2, m_level, m_press, m_rel;
    int   m_run;

    button_pulser #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .level(level),
        .press(press),
        .release_pulse(release_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic b;
        logic exp_level;
        logic exp_press;
        logic exp_rel;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_level = 1'b0;
        m_press = 1'b0; m_rel = 1'b0; m_run = 0;
        last_was_press = 1'b0;
    endtask

    // One clock edge of the abstract model: a change is accepted when the
    // synchronized input has disagreed with the level for D+1 samples.
    task automatic model_edge(input logic b);
        if (!rst) begin
            model_reset();
        end else begin
            m_press = 1'b0;
            m_rel   = 1'b0;
            if (m_s2 != m_level) begin
                m_run++;
                if (m_run == D + 1) begin
                    m_level = ~m_level;
                    m_press = m_level;
                    m_rel   = ~m_level;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_s2 = m_s1;
            m_s1 = b;
        end
    endtask

    // Called away from the rising edge; drives btn, advances one edge, checks.
    task automatic step(input logic b);
        btn = b;
        @(posedge clk);
        model_edge(b);
        #1;
        chk("level", level, m_level);
        chk("press", press, m_press);
        chk("release", release_pulse, m_rel);
        chk("exclusive", press & release_pulse, 1'b0);
        if (press === 1'b1) begin
            n_press++;
            chk("alternate_press", last_was_press, 1'b0);
            last_was_press = 1'b1;
        end
        if (release_pulse === 1'b1) begin
            n_rel++;
            chk("alternate_release", last_was_press, 1'b1);
            last_was_press = 1'b0;
        end
        @(negedge clk);
    endtask

    // Asserts reset mid-cycle and checks that outputs clear without an edge.
    task automatic assert_reset(input logic b);
        btn = b;
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async_rst_level", level, 1'b0);
        chk("async_rst_press", press, 1'b0);
        chk("async_rst_release", release_pulse, 1'b0);
    endtask

    initial begin
        int p0, r0;
        rst = 1'b0;
        btn = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) step(1'b0);

        // ---- table: clean press then clean release from IDLE ----
        for (int i = 0; i < 20; i++) begin
            vecs[i].b         = (i < 8) ? 1'b1 : 1'b0;
            vecs[i].exp_level = (i >= 6 && i < 14) ? 1'b1 : 1'b0;
            vecs[i].exp_press = (i == 6) ? 1'b1 : 1'b0;
            vecs[i].exp_rel   = (i == 14) ? 1'b1 : 1'b0;
        end
        p0 = n_press; r0 = n_rel;
        for (int i = 0; i < 20; i++) begin
            step(vecs[i].b);
            chk("tbl_level", level, vecs[i].exp_level);
            chk("tbl_press", press, vecs[i].exp_press);
            chk("tbl_release", release_pulse, vecs[i].exp_rel);
        end
        chk_int("tbl_press_count", n_press - p0, 1);
        chk_int("tbl_release_count", n_rel - r0, 1);

        // ---- reset held with btn toggling, then release with btn high ----
        assert_reset(1'b1);
        for (int i = 0; i < 6; i++) begin
            step(i[0]);
            chk("in_rst_level", level, 1'b0);
            chk("in_rst_press", press, 1'b0);
            chk("in_rst_release", release_pulse, 1'b0);
        end
        p0 = n_press;
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step(1'b1);
            chk("rst_rel_press", press, (k == 6) ? 1'b1 : 1'b0);
            chk("rst_rel_level", level, (k >= 6) ? 1'b1 : 1'b0);
        end
        chk_int("rst_rel_press_count", n_press - p0, 1);
        repeat (12) step(1'b0);

        // ---- bounce from IDLE ----
        p0 = n_press; r0 = n_rel;
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 1'b1 : 1'b0);
        repeat (10) step(1'b0);
        chk_int("bounce_idle_press", n_press - p0, 0);
        chk_int("bounce_idle_release", n_rel - r0, 0);
        chk("bounce_idle_level", level, 1'b0);

        // ---- bounce from HELD ----
        repeat (10) step(1'b1);
        chk("held_level", level, 1'b1);
        r0 = n_rel;
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? 1'b0 : 1'b1);
        repeat (10) step(1'b1);
        chk_int("bounce_held_release", n_rel - r0, 0);
        chk("bounce_held_level", level, 1'b1);
        repeat (12) step(1'b0);
        chk("after_release_level", level, 1'b0);

        // ---- mid-debounce reset: press must never appear ----
        p0 = n_press;
        for (int k = 0; k <= 4; k++) step(1'b1);
        assert_reset(1'b1);
        repeat (8) step(1'b1);
        chk_int("mid_rst_press", n_press - p0, 0);
        btn = 1'b0;
        rst = 1'b1;
        repeat (6) step(1'b0);
        chk_int("mid_rst_after_press", n_press - p0, 0);

        // ---- three clean presses, 12 high / 12 low ----
        p0 = n_press; r0 = n_rel;
        for (int n = 0; n < 3; n++) begin
            repeat (12) step(1'b1);
            repeat (12) step(1'b0);
        end
        chk_int("repeat_press", n_press - p0, 3);
        chk_int("repeat_release", n_rel - r0, 3);

        // ---- randomized runs with occasional resets ----
        for (int n = 0; n < 400; n++) begin
            logic b;
            int len;
            b = 1'($urandom_range(0, 1));
            len = int'($urandom_range(1, 9));
            if ($urandom_range(0, 39) == 0) begin
                assert_reset(b);
                step(b);
                rst = 1'b1;
            end
            for (int k = 0; k < len; k++) step(b);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
